// File: rtl/loop_sequencer.sv
// Step sequencer for the 8-track looper: drives the shared step address, record/clear
// writes into the note store, and merges the read-back notes into one playable vector.
module loop_sequencer #(
   parameter int unsigned TICKS_PER_STEP = 6250000,
   parameter int unsigned LOOP_STEPS     = 128,
   parameter int unsigned STEP_W         = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_en,
   input  logic              rec_arm,
   input  logic [2:0]        rec_track,
   input  logic              overdub,
   input  logic              clear_req,
   input  logic [7:0]        keys,
   input  logic [7:0]        track_mute,
   input  logic [63:0]       notes_q,
   output logic [STEP_W-1:0] trackCount,
   output logic [7:0]        trackChooser,
   output logic [7:0]        dataIn,
   output logic              step_tick,
   output logic [7:0]        mix_out,
   output logic              busy
);

   localparam int unsigned TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_STEP - 1);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(LOOP_STEPS - 1);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      CLEAR
   } seqState;

   seqState           state, stateNext;
   logic [TICK_W-1:0] tick, tickNext;
   logic [STEP_W-1:0] countNext;
   logic [7:0]        keyAcc, keyAccNext;
   logic [7:0]        mixNext;
   logic [2:0]        clearTrack, clearTrackNext;
   logic [7:0]        trackNotes [8];
   logic [7:0]        mergedNotes;
   logic [7:0]        chooserComb, dataComb;
   logic              stepComb, busyComb;

   always_comb begin
      mergedNotes = '0;
      for (int unsigned t = 0; t < 8; t++) begin
         trackNotes[t] = notes_q[8*t +: 8];
         if (!track_mute[t]) mergedNotes = mergedNotes | trackNotes[t];
      end
   end

   always_comb begin
      stateNext      = state;
      tickNext       = tick;
      countNext      = trackCount;
      keyAccNext     = keyAcc;
      mixNext        = mix_out;
      clearTrackNext = clearTrack;
      chooserComb    = '0;
      dataComb       = '0;
      stepComb       = 1'b0;
      busyComb       = 1'b0;

      unique case (state)
         IDLE: begin
            mixNext = keys;
            if (clear_req) begin
               stateNext      = CLEAR;
               countNext      = '0;
               tickNext       = '0;
               clearTrackNext = rec_track;
            end else if (play_en) begin
               stateNext = PLAY;
               tickNext  = '0;
            end
         end

         PLAY: begin
            stepComb   = (tick == '0);
            keyAccNext = ((tick == '0) ? 8'h00 : keyAcc) | keys;
            if (tick >= TICK_W'(2)) mixNext = mergedNotes | keys;
            if (clear_req) begin
               // Clear wins over a pending write; the position is abandoned.
               stateNext      = CLEAR;
               countNext      = '0;
               tickNext       = '0;
               clearTrackNext = rec_track;
            end else if (tick == LAST_TICK) begin
               if (rec_arm) begin
                  chooserComb[rec_track] = 1'b1;
                  dataComb = keyAcc | keys | (overdub ? trackNotes[rec_track] : 8'h00);
               end
               tickNext  = '0;
               countNext = (trackCount == LAST_STEP) ? '0 : trackCount + STEP_W'(1);
               if (!play_en) stateNext = IDLE;
            end else begin
               tickNext = tick + TICK_W'(1);
            end
         end

         CLEAR: begin
            busyComb                = 1'b1;
            chooserComb[clearTrack] = 1'b1;
            mixNext                 = keys;
            if (trackCount == LAST_STEP) begin
               stateNext = IDLE;
               countNext = '0;
               tickNext  = '0;
            end else begin
               countNext = trackCount + STEP_W'(1);
            end
         end

         default: stateNext = IDLE;
      endcase

      // Gate with reset so a reset landing mid-clear cannot commit a write on that edge.
      if (!reset) begin
         chooserComb = '0;
         dataComb    = '0;
         stepComb    = 1'b0;
         busyComb    = 1'b0;
      end
   end

   assign trackChooser = chooserComb;
   assign dataIn       = dataComb;
   assign step_tick    = stepComb;
   assign busy         = busyComb;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         tick       <= '0;
         trackCount <= '0;
         keyAcc     <= '0;
         mix_out    <= '0;
         clearTrack <= '0;
      end else begin
         state      <= stateNext;
         tick       <= tickNext;
         trackCount <= countNext;
         keyAcc     <= keyAccNext;
         mix_out    <= mixNext;
         clearTrack <= clearTrackNext;
      end
   end

   chooserOneHot: assert property (@(posedge clk) $onehot0(trackChooser));
   dataIdleZero:  assert property (@(posedge clk) (trackChooser == '0) |-> (dataIn == '0));

endmodule
